// File: rtl/pipeline_ma_dphase.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ma_dphase
// Purpose  : Memory-access stage of the pipeline. It tracks the AHB3-Lite
//            data phase of loads and stores issued by EX, aligns and extends
//            load data, and presents the write-back payload to WB. Non-LSU
//            instructions pass straight through to WB with one cycle of
//            latency.
// Ports    : s_clk_i / s_resetn_i       clock, async active-low reset
//            s_flush_i / s_stall_i      pipeline flush, WB-side stall
//            s_lsu_approve_i            EX issued an address phase this cycle
//            s_exma_*                   instruction payload from EX
//            s_d_hready_i/hresp/hrdata  AHB data-phase response
//            s_stall_o                  MA cannot accept a new instruction
//            s_mawb_*                   registered write-back payload
// Revision : 1.0  initial release
// ============================================================================
module pipeline_ma_dphase #(
    parameter int                   IMISCON_W      = 3,
    parameter logic [IMISCON_W-1:0] IMISCON_BUSE   = 3'b101,
    parameter int                   ICTRL_UNIT_LSU = 1
) (
    input  logic                 s_clk_i,
    input  logic                 s_resetn_i,
    input  logic                 s_flush_i,
    input  logic                 s_stall_i,
    input  logic                 s_lsu_approve_i,
    input  logic [6:0]           s_exma_ictrl_i,
    input  logic [3:0]           s_exma_f_i,
    input  logic [4:0]           s_exma_rd_i,
    input  logic [31:0]          s_exma_val_i,
    input  logic [IMISCON_W-1:0] s_exma_imiscon_i,
    input  logic                 s_d_hready_i,
    input  logic                 s_d_hresp_i,
    input  logic [31:0]          s_d_hrdata_i,
    output logic                 s_stall_o,
    output logic                 s_mawb_we_o,
    output logic [4:0]           s_mawb_rd_o,
    output logic [31:0]          s_mawb_val_o,
    output logic [IMISCON_W-1:0] s_mawb_imiscon_o
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_dphase = 2'd1;
    localparam logic [1:0] c_err2   = 2'd2;
    localparam logic [1:0] c_drain  = 2'd3;

    logic [1:0]           r_state;
    logic [3:0]           r_f;
    logic [4:0]           r_rd;
    logic [1:0]           r_addr;
    logic [IMISCON_W-1:0] r_imiscon;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_shifted;
    logic [31:0] w_load_val;

    wire w_idle   = (r_state == c_idle);
    wire w_dphase = (r_state == c_dphase);
    wire w_err2   = (r_state == c_err2);
    wire w_drain  = (r_state == c_drain);
    wire w_busy   = !w_idle;

    // Bus-phase events for the transfer currently owned by this stage.
    wire w_bus_done   = w_dphase && s_d_hready_i && !s_d_hresp_i;
    wire w_err_enter  = w_dphase && s_d_hresp_i && !s_d_hready_i;
    // An error whose second cycle is already visible in DPHASE finishes at once.
    wire w_err_done   = (w_err2 && s_d_hready_i) ||
                        (w_dphase && s_d_hresp_i && s_d_hready_i);
    wire w_drain_done = w_drain && s_d_hready_i;

    // Stage can take a new address phase from EX at the coming edge.
    wire w_free = w_idle || w_bus_done || w_err_done || w_drain_done;

    wire w_nonlsu = (s_exma_ictrl_i != 7'd0) && !s_exma_ictrl_i[ICTRL_UNIT_LSU];
    // Pass-through only when no bus result competes for the WB slot.
    wire w_pass   = (w_idle || w_drain_done) && w_nonlsu;

    assign s_stall_o = s_stall_i ||
                       (w_dphase && !s_d_hready_i) ||
                       w_err2 ||
                       (w_drain && !s_d_hready_i);

    // Next-state: a flush never aborts a bus transfer already on the wire; a
    // transfer still waiting for hready (or one issued alongside the flush)
    // is drained instead of completed.
    always_comb begin
        w_state_nxt = r_state;
        if (s_flush_i) begin
            if (w_busy && !s_d_hready_i) begin
                w_state_nxt = c_drain;
            end else if (s_lsu_approve_i) begin
                w_state_nxt = c_drain;
            end else begin
                w_state_nxt = c_idle;
            end
        end else if (w_free) begin
            w_state_nxt = s_lsu_approve_i ? c_dphase : c_idle;
        end else if (w_err_enter) begin
            w_state_nxt = c_err2;
        end
    end

    // Load alignment and sign/zero extension.
    assign w_shifted = s_d_hrdata_i >> {r_addr, 3'b000};

    always_comb begin
        w_load_val = w_shifted;
        case (r_f[1:0])
            2'b00:   w_load_val = r_f[2] ? {24'd0, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_val = r_f[2] ? {16'd0, w_shifted[15:0]}
                                         : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_val = w_shifted;
        endcase
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_state          <= c_idle;
            r_f              <= 4'd0;
            r_rd             <= 5'd0;
            r_addr           <= 2'd0;
            r_imiscon        <= '0;
            s_mawb_we_o      <= 1'b0;
            s_mawb_rd_o      <= 5'd0;
            s_mawb_val_o     <= 32'd0;
            s_mawb_imiscon_o <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_free && s_lsu_approve_i) begin
                r_f       <= s_exma_f_i;
                r_rd      <= s_exma_rd_i;
                r_addr    <= s_exma_val_i[1:0];
                r_imiscon <= s_exma_imiscon_i;
            end

            if (s_flush_i) begin
                s_mawb_we_o      <= 1'b0;
                s_mawb_rd_o      <= 5'd0;
                s_mawb_val_o     <= 32'd0;
                s_mawb_imiscon_o <= '0;
            end else if (s_stall_i) begin
                s_mawb_we_o      <= s_mawb_we_o;
            end else if (w_bus_done) begin
                // Stores (f[3]=1) never write the register file.
                s_mawb_we_o      <= !r_f[3] && (r_rd != 5'd0) && (r_imiscon == '0);
                s_mawb_rd_o      <= r_rd;
                s_mawb_val_o     <= w_load_val;
                s_mawb_imiscon_o <= r_imiscon;
            end else if (w_err_done) begin
                s_mawb_we_o      <= 1'b0;
                s_mawb_rd_o      <= r_rd;
                s_mawb_val_o     <= 32'd0;
                s_mawb_imiscon_o <= IMISCON_BUSE;
            end else if (w_pass) begin
                s_mawb_we_o      <= (s_exma_rd_i != 5'd0) && (s_exma_imiscon_i == '0);
                s_mawb_rd_o      <= s_exma_rd_i;
                s_mawb_val_o     <= s_exma_val_i;
                s_mawb_imiscon_o <= s_exma_imiscon_i;
            end else begin
                s_mawb_we_o      <= 1'b0;
                s_mawb_imiscon_o <= '0;
            end
        end
    end

endmodule
`default_nettype wire
